// File: rtl/dtcm_ahb_slave.sv
// dtcm_ahb_slave: zero-wait AHB-Lite responder in front of the single-port DTCM SRAM.
// Stores are absorbed into a one-entry write buffer that drains on cycles with no read issue.
module dtcm_ahb_slave #(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hsel,
    input  logic [31:0]       haddr,
    input  logic [1:0]        htrans,
    input  logic              hwrite,
    input  logic [2:0]        hsize,
    input  logic [31:0]       hwdata,
    output logic [31:0]       hrdata,
    output logic              hready,
    output logic              sram_cs,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [3:0]        sram_wbe,
    output logic [31:0]       sram_wdata,
    input  logic [31:0]       sram_rdata
);

    logic              rd_dph_q, rd_dph_d;
    logic              wr_dph_q, wr_dph_d;
    logic [ADDR_W-1:0] dph_addr_q, dph_addr_d;
    logic [3:0]        dph_be_q, dph_be_d;
    logic              buf_v_q, buf_v_d;
    logic [ADDR_W-1:0] buf_addr_q, buf_addr_d;
    logic [3:0]        buf_be_q, buf_be_d;
    logic [31:0]       buf_data_q, buf_data_d;

    logic              bus_req;
    logic              accept;
    logic              rd_issue;
    logic              drain;
    logic              buf_load;
    logic              fwd_hit;
    logic [3:0]        be;
    logic [31:0]       dph_mask;
    logic              unused_ok;

    // Address bits above the SRAM depth alias; BUSY behaves like IDLE.
    assign unused_ok = ^{haddr[31:ADDR_W+2], htrans[0]};

    always_comb begin
        case (hsize)
            3'd0:    be = 4'b0001 << haddr[1:0];
            3'd1:    be = 4'b0011 << {haddr[1], 1'b0};
            default: be = 4'b1111;
        endcase
    end

    always_comb begin
        bus_req  = hsel & htrans[1];
        // Only a read arriving while a store is in its data phase and another
        // store still sits in the buffer has nowhere to go this cycle.
        hready   = ~(wr_dph_q & buf_v_q & bus_req & ~hwrite);
        accept   = bus_req & hready;
        rd_issue = accept & ~hwrite;
        drain    = buf_v_q & ~rd_issue;
        buf_load = wr_dph_q & hready;
        dph_mask = {{8{dph_be_q[3]}}, {8{dph_be_q[2]}}, {8{dph_be_q[1]}}, {8{dph_be_q[0]}}};

        rd_dph_d   = rd_dph_q;
        wr_dph_d   = wr_dph_q;
        dph_addr_d = dph_addr_q;
        dph_be_d   = dph_be_q;
        if (hready) begin
            rd_dph_d = rd_issue;
            wr_dph_d = accept & hwrite;
        end
        if (accept) begin
            dph_addr_d = haddr[ADDR_W+1:2];
            dph_be_d   = be;
        end

        buf_v_d    = buf_v_q;
        buf_addr_d = buf_addr_q;
        buf_be_d   = buf_be_q;
        buf_data_d = buf_data_q;
        if (buf_load) begin
            buf_v_d    = 1'b1;
            buf_addr_d = dph_addr_q;
            buf_be_d   = dph_be_q;
            buf_data_d = hwdata & dph_mask;
        end else if (drain) begin
            buf_v_d = 1'b0;
        end
    end

    always_comb begin
        fwd_hit = buf_v_q & (buf_addr_q == dph_addr_q);
        hrdata  = '0;
        if (rd_dph_q) begin
            for (int i = 0; i < 4; i++) begin
                hrdata[8*i +: 8] = (fwd_hit & buf_be_q[i]) ? buf_data_q[8*i +: 8]
                                                           : sram_rdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        sram_cs    = 1'b0;
        sram_we    = 1'b0;
        sram_addr  = '0;
        sram_wbe   = '0;
        sram_wdata = '0;
        if (rd_issue) begin
            sram_cs   = 1'b1;
            sram_addr = haddr[ADDR_W+1:2];
        end else if (drain) begin
            sram_cs    = 1'b1;
            sram_we    = 1'b1;
            sram_addr  = buf_addr_q;
            sram_wbe   = buf_be_q;
            sram_wdata = buf_data_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_dph_q   <= 1'b0;
            wr_dph_q   <= 1'b0;
            dph_addr_q <= '0;
            dph_be_q   <= '0;
            buf_v_q    <= 1'b0;
            buf_addr_q <= '0;
            buf_be_q   <= '0;
            buf_data_q <= '0;
        end else begin
            rd_dph_q   <= rd_dph_d;
            wr_dph_q   <= wr_dph_d;
            dph_addr_q <= dph_addr_d;
            dph_be_q   <= dph_be_d;
            buf_v_q    <= buf_v_d;
            buf_addr_q <= buf_addr_d;
            buf_be_q   <= buf_be_d;
            buf_data_q <= buf_data_d;
        end
    end

endmodule

// File: tb/tb_dtcm_ahb_slave.sv
// Bench for dtcm_ahb_slave: lane-strobe table, directed corner sequences, and a
// randomized run against a coherent-memory reference with a stall-rule predictor.
module tb_dtcm_ahb_slave;

    localparam int AW = 14;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          hsel;
    logic [31:0]   haddr;
    logic [1:0]    htrans;
    logic          hwrite;
    logic [2:0]    hsize;
    logic [31:0]   hwdata;
    logic [31:0]   hrdata;
    logic          hready;
    logic          sram_cs;
    logic          sram_we;
    logic [AW-1:0] sram_addr;
    logic [3:0]    sram_wbe;
    logic [31:0]   sram_wdata;
    logic [31:0]   sram_rdata;

    int n_chk  = 0;
    int n_fail = 0;
    int n_wr   = 0;

    always #5 clk = ~clk;

    dtcm_ahb_slave #(.ADDR_W(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .hsel       (hsel),
        .haddr      (haddr),
        .htrans     (htrans),
        .hwrite     (hwrite),
        .hsize      (hsize),
        .hwdata     (hwdata),
        .hrdata     (hrdata),
        .hready     (hready),
        .sram_cs    (sram_cs),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_wbe   (sram_wbe),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    // Synchronous SRAM model with a bench-side preload port.
    logic [31:0]   mem [0:(1<<AW)-1];
    logic          pre_we = 1'b0;
    logic [AW-1:0] pre_addr;
    logic [31:0]   pre_data;

    always @(posedge clk) begin
        if (pre_we) begin
            mem[pre_addr] <= pre_data;
        end else if (sram_cs) begin
            if (sram_we) begin
                for (int i = 0; i < 4; i++)
                    if (sram_wbe[i]) mem[sram_addr][8*i +: 8] <= sram_wdata[8*i +: 8];
            end else begin
                sram_rdata <= mem[sram_addr];
            end
        end
    end

    always @(posedge clk) if (sram_cs && sram_we) n_wr <= n_wr + 1;

    typedef struct {
        logic [2:0]    size;
        logic [31:0]   addr;
        logic [3:0]    be;
        logic [31:0]   wdata;
        logic [AW-1:0] idx;
    } vec_t;

    vec_t tbl [7];

    logic [31:0] ref_mem [0:7];
    logic        r_sel, r_write, stalled, exp_rdy;
    logic [1:0]  r_trans;
    logic [2:0]  r_size;
    logic [31:0] r_addr, r_wdata;
    logic [3:0]  dph_be_m;
    int          r_k, dph_k, dph_kind, hist1, hist2, acc_kind, wr0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic bus(input logic s, input logic [1:0] t, input logic w,
                       input logic [2:0] sz, input logic [31:0] a, input logic [31:0] d);
        hsel   = s;
        htrans = t;
        hwrite = w;
        hsize  = sz;
        haddr  = a;
        hwdata = d;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [31:0] d);
        pre_addr = a;
        pre_data = d;
        pre_we   = 1'b1;
        cyc();
        pre_we   = 1'b0;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_hready"}, 32'(hready), 32'd1);
        chk({tag, "_hrdata"}, hrdata, 32'd0);
        chk({tag, "_cs"}, 32'(sram_cs), 32'd0);
        chk({tag, "_we"}, 32'(sram_we), 32'd0);
        chk({tag, "_addr"}, 32'(sram_addr), 32'd0);
        chk({tag, "_wbe"}, 32'(sram_wbe), 32'd0);
        chk({tag, "_wdata"}, sram_wdata, 32'd0);
    endtask

    function automatic logic [3:0] lanes(input logic [2:0] sz, input logic [1:0] a);
        case (sz)
            3'd0:    lanes = 4'b0001 << a;
            3'd1:    lanes = a[1] ? 4'b1100 : 4'b0011;
            default: lanes = 4'b1111;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{3'd0, 32'h0000_0400, 4'b0001, 32'h0000_00D4, 14'h100};
        tbl[1] = '{3'd0, 32'h0000_0403, 4'b1000, 32'hA100_0000, 14'h100};
        tbl[2] = '{3'd1, 32'h0000_0402, 4'b1100, 32'hA1B2_0000, 14'h100};
        tbl[3] = '{3'd1, 32'h0000_0401, 4'b0011, 32'h0000_C3D4, 14'h100};
        tbl[4] = '{3'd2, 32'h0000_0407, 4'b1111, 32'hA1B2_C3D4, 14'h101};
        tbl[5] = '{3'd5, 32'h0000_0408, 4'b1111, 32'hA1B2_C3D4, 14'h102};
        tbl[6] = '{3'd0, 32'h0001_0402, 4'b0100, 32'h00B2_0000, 14'h100};

        rst_n = 1'b0;
        bus(0, 2'b00, 0, 3'd0, 32'h0, 32'h0);
        #2;
        chk_reset_outs("reset");

        preload(14'h040, 32'h0000_0000);
        preload(14'h080, 32'h1122_3344);
        preload(14'h0C0, 32'h0000_0000);
        preload(14'h140, 32'hCAFE_F00D);
        preload(14'h180, 32'h600D_BEEF);
        for (int k = 0; k < 8; k++) begin
            preload(14'(14'h800 + k), 32'h3C00_0000 + 32'(k) * 32'h0001_0203);
            ref_mem[k] = 32'h3C00_0000 + 32'(k) * 32'h0001_0203;
        end
        rst_n = 1'b1;
        cyc();

        // Lane strobes and masked write data, observed on the drain cycle.
        for (int v = 0; v < 7; v++) begin
            bus(1, 2'b10, 1, tbl[v].size, tbl[v].addr, 32'h0);
            cyc();
            bus(0, 2'b00, 0, 3'd0, 32'h0, 32'hA1B2_C3D4);
            cyc();
            bus(0, 2'b00, 0, 3'd0, 32'h0, 32'h0);
            @(negedge clk);
            chk("tbl_cs", 32'(sram_cs), 32'd1);
            chk("tbl_we", 32'(sram_we), 32'd1);
            chk("tbl_wbe", 32'(sram_wbe), 32'(tbl[v].be));
            chk("tbl_wdata", sram_wdata, tbl[v].wdata);
            chk("tbl_addr", 32'(sram_addr), 32'(tbl[v].idx));
            cyc();
        end

        // Word store then immediate load of the same address.
        bus(1, 2'b10, 1, 3'd2, 32'h100, 32'h0);
        @(negedge clk); chk("st_ld_hready0", 32'(hready), 32'd1);
        cyc();
        bus(1, 2'b10, 0, 3'd2, 32'h100, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("st_ld_hready1", 32'(hready), 32'd1);
        chk("st_ld_rd_cs", 32'(sram_cs), 32'd1);
        chk("st_ld_rd_we", 32'(sram_we), 32'd0);
        chk("st_ld_rd_addr", 32'(sram_addr), 32'h40);
        cyc();
        bus(0, 2'b00, 0, 3'd0, 32'h0, 32'h0);
        @(negedge clk);
        chk("st_ld_hready2", 32'(hready), 32'd1);
        chk("st_ld_hrdata", hrdata, 32'hDEAD_BEEF);
        chk("st_ld_drain_we", 32'(sram_we), 32'd1);
        chk("st_ld_drain_wbe", 32'(sram_wbe), 32'hF);
        chk("st_ld_drain_data", sram_wdata, 32'hDEAD_BEEF);
        cyc();
        @(negedge clk);
        chk("st_ld_idle_cs", 32'(sram_cs), 32'd0);
        chk("st_ld_idle_hrdata", hrdata, 32'd0);
        chk("st_ld_mem", mem[14'h040], 32'hDEAD_BEEF);
        cyc();

        // Byte store merged into a following word load.
        bus(1, 2'b10, 1, 3'd0, 32'h201, 32'h0);
        cyc();
        bus(1, 2'b10, 0, 3'd2, 32'h200, 32'h0000_AA00);
        @(negedge clk); chk("merge_hready", 32'(hready), 32'd1);
        cyc();
        bus(0, 2'b00, 0, 3'd0, 32'h0, 32'h0);
        @(negedge clk);
        chk("merge_hrdata", hrdata, 32'h1122_AA44);
        chk("merge_drain_wbe", 32'(sram_wbe), 32'b0010);
        chk("merge_drain_data", sram_wdata, 32'h0000_AA00);
        cyc();
        chk("merge_mem", mem[14'h080], 32'h1122_AA44);

        // Store A, store B, load C: one wait state.
        bus(1, 2'b10, 1, 3'd2, 32'h604, 32'h0);
        cyc();
        bus(1, 2'b11, 1, 3'd2, 32'h608, 32'h0A0A_0A0A);
        @(negedge clk);
        chk("ssr_hready_b_addr", 32'(hready), 32'd1);
        chk("ssr_cs_b_addr", 32'(sram_cs), 32'd0);
        cyc();
        bus(1, 2'b10, 0, 3'd2, 32'h600, 32'h0B0B_0B0B);
        @(negedge clk);
        chk("ssr_stall", 32'(hready), 32'd0);
        chk("ssr_drain_a_we", 32'(sram_we), 32'd1);
        chk("ssr_drain_a_addr", 32'(sram_addr), 32'h181);
        chk("ssr_drain_a_data", sram_wdata, 32'h0A0A_0A0A);
        cyc();
        @(negedge clk);
        chk("ssr_after_stall", 32'(hready), 32'd1);
        chk("ssr_rd_cs", 32'(sram_cs), 32'd1);
        chk("ssr_rd_we", 32'(sram_we), 32'd0);
        chk("ssr_rd_addr", 32'(sram_addr), 32'h180);
        cyc();
        bus(0, 2'b00, 0, 3'd0, 32'h0, 32'h0);
        @(negedge clk);
        chk("ssr_hrdata_c", hrdata, 32'h600D_BEEF);
        chk("ssr_drain_b_we", 32'(sram_we), 32'd1);
        chk("ssr_drain_b_addr", 32'(sram_addr), 32'h182);
        chk("ssr_drain_b_data", sram_wdata, 32'h0B0B_0B0B);
        cyc();

        // Halfword store to upper half, idle drain, later load.
        bus(1, 2'b10, 1, 3'd1, 32'h302, 32'h0);
        cyc();
        bus(0, 2'b00, 0, 3'd0, 32'h0, 32'h5566_0000);
        @(negedge clk); chk("half_no_early_write", 32'(sram_cs), 32'd0);
        cyc();
        bus(0, 2'b00, 0, 3'd0, 32'h0, 32'h0);
        @(negedge clk);
        chk("half_we", 32'(sram_we), 32'd1);
        chk("half_wbe", 32'(sram_wbe), 32'b1100);
        chk("half_wdata_hi", 32'(sram_wdata[31:16]), 32'h5566);
        cyc();
        bus(1, 2'b10, 0, 3'd1, 32'h300, 32'h0);
        cyc();
        bus(0, 2'b00, 0, 3'd0, 32'h0, 32'h0);
        @(negedge clk); chk("half_load", hrdata, 32'h5566_0000);
        cyc();

        // Not-selected and BUSY transfers must not touch the SRAM.
        bus(0, 2'b10, 1, 3'd2, 32'h100, 32'h0);
        @(negedge clk);
        chk("nosel_cs", 32'(sram_cs), 32'd0);
        chk("nosel_hready", 32'(hready), 32'd1);
        cyc();
        bus(1, 2'b01, 0, 3'd2, 32'h100, 32'h1234_5678);
        @(negedge clk);
        chk("busy_cs", 32'(sram_cs), 32'd0);
        chk("busy_hready", 32'(hready), 32'd1);
        cyc();
        bus(0, 2'b00, 0, 3'd0, 32'h0, 32'h0);
        @(negedge clk);
        chk("busy_no_dph_hrdata", hrdata, 32'd0);
        chk("busy_no_dph_cs", 32'(sram_cs), 32'd0);
        cyc();

        // Reset pulsed during a store data phase.
        bus(1, 2'b10, 1, 3'd2, 32'h500, 32'h0);
        cyc();
        bus(0, 2'b00, 0, 3'd0, 32'h0, 32'h1234_5678);
        wr0 = n_wr;
        #2 rst_n = 1'b0;
        #1 chk_reset_outs("rst_mid");
        cyc();
        cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) cyc();
        chk("rst_no_write", 32'(n_wr - wr0), 32'd0);
        bus(1, 2'b10, 0, 3'd2, 32'h500, 32'h0);
        cyc();
        bus(0, 2'b00, 0, 3'd0, 32'h0, 32'h0);
        @(negedge clk); chk("rst_old_content", hrdata, 32'hCAFE_F00D);
        cyc();
        cyc();

        // Randomized traffic against the coherent-memory reference.
        dph_kind = 0;
        dph_k    = 0;
        dph_be_m = 4'b0;
        hist1    = 0;
        hist2    = 0;
        stalled  = 1'b0;
        r_k      = 0;
        for (int n = 0; n < 2004; n++) begin
            if (!stalled) begin
                r_sel   = (n < 2000) && ($urandom_range(0, 7) != 0);
                r_trans = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 1))
                                                      : 2'($urandom_range(2, 3));
                r_write = 1'($urandom_range(0, 1));
                r_size  = 3'($urandom_range(0, 3));
                r_k     = int'($urandom_range(0, 7));
                r_addr  = {16'($urandom), 16'(32'h2000 + 32'(r_k) * 4 + 32'($urandom_range(0, 3)))};
                r_wdata = $urandom;
            end
            bus(r_sel, r_trans, r_write, r_size, r_addr, r_wdata);
            @(negedge clk);
            exp_rdy = !(hist1 == 2 && hist2 == 2 && r_sel && r_trans[1] && !r_write);
            chk("rnd_hready", 32'(hready), 32'(exp_rdy));
            chk("rnd_hrdata", hrdata, (dph_kind == 1) ? ref_mem[dph_k] : 32'h0);
            if (dph_kind == 2 && exp_rdy)
                for (int l = 0; l < 4; l++)
                    if (dph_be_m[l]) ref_mem[dph_k][8*l +: 8] = r_wdata[8*l +: 8];
            acc_kind = (r_sel && r_trans[1] && exp_rdy) ? (r_write ? 2 : 1) : 0;
            if (exp_rdy) begin
                dph_kind = acc_kind;
                if (acc_kind != 0) begin
                    dph_k    = r_k;
                    dph_be_m = lanes(r_size, r_addr[1:0]);
                end
            end
            hist2   = hist1;
            hist1   = acc_kind;
            stalled = !exp_rdy;
            cyc();
        end
        bus(0, 2'b00, 0, 3'd0, 32'h0, 32'h0);
        cyc();
        cyc();
        for (int k = 0; k < 8; k++)
            chk("rnd_sram_final", mem[14'(14'h800 + k)], ref_mem[k]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dtcm_ahb_slave.md
# dtcm_ahb_slave

AHB-Lite responder fronting the single-port data SRAM (DTCM) that the EX-stage load/store unit addresses through its `d_h*` master port. It decodes transfers, serves byte/halfword/word reads with zero wait states, and absorbs stores into a one-entry write buffer. The buffer drains to the SRAM on idle port cycles, with byte-merged read forwarding. It inserts a single wait state only when a pending store and a new store collide with a read.

## Interface
- `ADDR_W`, 14: SRAM word-address width (depth 2^ADDR_W words, 64 KB default).
- `clk` in 1: core clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `hsel` in 1: DTCM select from the address decoder.
- `haddr` in 32: byte address. Bits [ADDR_W+1:2] form the word index; bits [1:0] select byte lanes.
- `htrans` in 2: 00 IDLE, 01 BUSY (treated as IDLE), 10 NONSEQ, 11 SEQ.
- `hwrite` in 1: 1 = store.
- `hsize` in 3: 0 byte, 1 halfword, 2 word. Other values are treated as word.
- `hwdata` in 32: store data, valid in the data phase.
- `hrdata` out 32: load data, valid in the read data phase while `hready`=1.
- `hready` out 1: transfer-done/accept. This is the only bus ready; the master feeds it back as `d_hready`.
- `sram_cs` out 1: SRAM access strobe.
- `sram_we` out 1: 1 = write.
- `sram_addr` out ADDR_W: word address.
- `sram_wbe` out 4: byte write enables.
- `sram_wdata` out 32: write data.
- `sram_rdata` in 32: synchronous SRAM read data, valid the cycle after `sram_cs & ~sram_we`.

## Operation
- Accepted transfer: `hsel & htrans[1] & hready` at a rising edge.
- Byte-lane strobe `be` is computed from `hsize` and `haddr[1:0]`:
  - byte: `1<<a[1:0]`
  - half: `4'b0011<<{a[1],1'b0}`
  - word: `4'hF`
  - Misalignment is not checked; `haddr[0]` is ignored for halfwords and `haddr[1:0]` is ignored for words.
- No error response. Addresses above the SRAM depth alias (upper bits ignored).
- Registered data-phase state: `rd_dph`, `wr_dph`, `dph_addr`, `dph_be`.
- Write buffer: `buf_v`, `buf_addr`, `buf_be`, `buf_data`.
- Store path:
  - In the write data phase with `hready`=1, the buffer loads `{dph_addr, dph_be, hwdata masked per lane}`.
  - `buf_v` is set at the end of that cycle.
- Load path:
  - An accepted read in its address phase drives `sram_cs=1`, `sram_we=0`, `sram_addr=haddr` word index.
  - In the data phase, for each byte lane: `hrdata` = `buf_data` lane if `buf_v & buf_addr==dph_addr & buf_be[lane]`, otherwise the `sram_rdata` lane.
  - The full word is returned on every lane; the master extracts its lanes.
- Drain:
  - When `buf_v` and no read is being issued this cycle, drive `sram_cs=1`, `sram_we=1`, `sram_addr=buf_addr`, `sram_wbe=buf_be`, `sram_wdata=buf_data`.
  - `buf_v` clears at the end of the cycle unless reloaded by a store in that same cycle.
- Read issue has priority over drain.
- Collision stall:
  - `hready = ~(wr_dph & buf_v & hsel & htrans[1] & ~hwrite)`. This is combinational from registers and bus inputs only; it does not depend on `sram_rdata`.
  - During the stall cycle no read is issued, the buffer drains, and the store and next address are held by the master.
  - Next cycle: `hready`=1, the store loads the empty buffer, and the read issues.
- Outside a read data phase, `hrdata` is 0.
- `sram_cs` is 0 when neither a read nor a drain occurs.

## Timing
- Reset values:
  - `hready`=1, `hrdata`=0
  - `sram_cs`=0, `sram_we`=0, `sram_addr`=0, `sram_wbe`=0, `sram_wdata`=0
  - `buf_v`=0, `rd_dph`=0, `wr_dph`=0
- Read latency: address accepted at cycle t, `hrdata` valid in t+1 with `hready`=1 (zero wait).
- Store: address at t, `hwdata` at t+1, buffered at the end of t+1, SRAM write at the earliest cycle ≥ t+2 with no read issue.
- Only the store/store/read collision inserts a wait state, exactly one cycle. Back-to-back stores never stall: drain and reload happen in the same cycle.
- A read that follows a store immediately sees the store's data via forwarding, including partial-lane merge.
- Reset asserted mid-operation: the pending buffered store is discarded and the data phase is abandoned. Outputs return to reset values asynchronously.
- `htrans`=BUSY or `hsel`=0: no access. An existing buffer drains.

## Test plan
- Word store `0x100`=`0xDEADBEEF`, then word load `0x100` back-to-back -> `hrdata=0xDEADBEEF` in the load data phase, `hready` never low; SRAM write occurs one cycle later.
- SRAM word `0x200` preloaded `0x11223344`; byte store `0x201`=`0xAA`; immediate load `0x200` -> `hrdata=0x1122AA44`, `sram_wbe=4'b0010` on drain.
- Store A, store B, load C consecutively -> exactly one cycle `hready`=0 during B's data phase. A drains in the stall cycle, the load of C returns SRAM data of C, and B drains afterward.
- Halfword store `0x302`=`0x5566` then idle -> `sram_we=1`, `sram_wbe=4'b1100`, `sram_wdata[31:16]=0x5566`; a later load `0x300` returns the upper half `0x5566`.
- `hsel`=0 or `htrans`=BUSY with valid-looking `haddr`/`hwrite` -> `sram_cs` stays 0 (buffer empty), `hready`=1.
- Store accepted, `rst_n` pulsed low in its data phase -> no SRAM write ever occurs, all outputs at reset values, first post-reset load returns the old SRAM content.
